ama_riscv_mem_arbiter: RTL and testbench

AMA_RISCV_MEM_ARBITER -- requirements
Module: ama_riscv_mem_arbiter

---
 rtl/ama_riscv_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_ama_riscv_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ama_riscv_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Data side has priority, with a bounded starvation counter protecting fetch.
module ama_riscv_mem_arbiter #(
  parameter int AW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          i_flush,
  output logic          i_gnt,
  output logic          i_ack,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  input  logic [3:0]    d_wstrb,
  output logic          d_gnt,
  output logic          d_ack,
  output logic [31:0]   d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          drop_q, drop_d;
  logic          store_q, store_d;
  logic          starve_hit;

  assign starve_hit = (starve_q == STARVE_TOP);

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    drop_d    = drop_q;
    store_d   = store_q;
    i_gnt     = 1'b0;
    i_ack     = 1'b0;
    i_rdata   = '0;
    d_gnt     = 1'b0;
    d_ack     = 1'b0;
    d_rdata   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;

    case (state_q)
      IDLE: begin
        if (d_req && !(i_req && starve_hit)) begin
          d_gnt     = 1'b1;
          mem_req   = 1'b1;
          mem_we    = d_we;
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
          mem_wstrb = d_wstrb;
          store_d   = d_we;
          state_d   = BUSY_D;
          if (!i_req) begin
            starve_d = '0;
          end else if (!starve_hit) begin
            starve_d = starve_q + STARVE_ONE;
          end
        end else if (i_req && (d_req || !i_flush)) begin
          // a flush coinciding with the grant kills the fetch before it returns
          i_gnt    = 1'b1;
          mem_req  = 1'b1;
          mem_addr = i_addr;
          drop_d   = i_flush;
          starve_d = '0;
          state_d  = BUSY_I;
        end else if (!i_req) begin
          starve_d = '0;
        end
      end
      BUSY_I: begin
        if (mem_ack) begin
          if (!(drop_q || i_flush)) begin
            i_ack   = 1'b1;
            i_rdata = mem_rdata;
          end
          drop_d  = 1'b0;
          state_d = IDLE;
        end else if (i_flush) begin
          drop_d = 1'b1;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          d_ack   = 1'b1;
          d_rdata = store_q ? '0 : mem_rdata;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // outputs are combinational, so reset must mask them directly
    if (!rst_n) begin
      i_gnt     = 1'b0;
      i_ack     = 1'b0;
      i_rdata   = '0;
      d_gnt     = 1'b0;
      d_ack     = 1'b0;
      d_rdata   = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
      drop_q   <= 1'b0;
      store_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      drop_q   <= drop_d;
      store_q  <= store_d;
    end
  end

endmodule

// File: tb/tb_ama_riscv_mem_arbiter.sv
// Bench for ama_riscv_mem_arbiter: directed scenarios plus random traffic,
// all checked each cycle against a transaction-level model.
module tb_ama_riscv_mem_arbiter;
  localparam int AW = 32;
  localparam int STARVE_MAX = 4;

  logic          clk, rst_n;
  logic          i_req, i_flush, i_gnt, i_ack;
  logic [AW-1:0] i_addr;
  logic [31:0]   i_rdata;
  logic          d_req, d_we, d_gnt, d_ack;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata, d_rdata;
  logic [3:0]    d_wstrb;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [3:0]    mem_wstrb;

  ama_riscv_mem_arbiter #(.AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
    .i_gnt(i_gnt), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // memory responder state
  int          mem_lat = 1;     // 0 selects a random latency 1..4
  int          mem_cnt = 0;
  bit          fixed_en = 0;
  logic [31:0] fixed_data = '0;

  // per-cycle samples taken at the falling edge
  logic s_i_gnt, s_d_gnt, s_i_ack, s_d_ack, s_mem_req, s_mem_we;
  logic [31:0] s_i_rdata, s_d_rdata, s_mem_addr, s_mem_wdata;
  logic [3:0]  s_mem_wstrb;

  task automatic cyc();
    @(negedge clk);
    s_i_gnt = i_gnt;  s_d_gnt = d_gnt;  s_i_ack = i_ack;  s_d_ack = d_ack;
    s_i_rdata = i_rdata;  s_d_rdata = d_rdata;
    s_mem_req = mem_req;  s_mem_we = mem_we;  s_mem_addr = mem_addr;
    s_mem_wdata = mem_wdata;  s_mem_wstrb = mem_wstrb;
    if (mem_req) mem_cnt = (mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat;
    @(posedge clk);
    #1;
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = fixed_en ? fixed_data : $urandom;
      end
    end
  endtask

  // behavioural model: at most one transaction in flight, plus a count of
  // data grants that went past a waiting fetch
  bit    m_busy = 0, m_is_d = 0, m_store = 0, m_drop = 0;
  int    m_starve = 0;
  bit    collect = 0;
  string model_order = "";
  string dut_order   = "";
  logic        e_ig, e_dg, e_ia, e_da, e_mreq, e_mwe;
  logic [31:0] e_ird, e_drd, e_maddr, e_mwd;
  logic [3:0]  e_mws;

  initial begin : cmp
    forever begin
      @(negedge clk);
      e_ig = 0; e_dg = 0; e_ia = 0; e_da = 0; e_mreq = 0; e_mwe = 0;
      e_ird = 0; e_drd = 0; e_maddr = 0; e_mwd = 0; e_mws = 0;
      if (!rst_n) begin
        m_busy = 0; m_starve = 0; m_drop = 0;
      end else if (!m_busy) begin
        if (d_req && !(i_req && m_starve >= STARVE_MAX)) begin
          e_dg = 1; e_mreq = 1; e_mwe = d_we; e_maddr = d_addr; e_mwd = d_wdata; e_mws = d_wstrb;
          m_busy = 1; m_is_d = 1; m_store = d_we;
          m_starve = i_req ? ((m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1) : 0;
        end else if (i_req && (d_req || !i_flush)) begin
          e_ig = 1; e_mreq = 1; e_maddr = i_addr;
          m_busy = 1; m_is_d = 0; m_drop = i_flush; m_starve = 0;
        end else if (!i_req) begin
          m_starve = 0;
        end
      end else if (mem_ack) begin
        if (m_is_d) begin
          e_da = 1; e_drd = m_store ? 32'h0 : mem_rdata;
        end else if (!(m_drop || i_flush)) begin
          e_ia = 1; e_ird = mem_rdata;
        end
        m_busy = 0; m_drop = 0;
      end else if (!m_is_d && i_flush) begin
        m_drop = 1;
      end
      if (collect) begin
        if (e_dg) model_order = {model_order, "D"};
        if (e_ig) model_order = {model_order, "I"};
        if (d_gnt) dut_order = {dut_order, "D"};
        if (i_gnt) dut_order = {dut_order, "I"};
      end
      chk("gnt",   80'({i_gnt, d_gnt}), 80'({e_ig, e_dg}));
      chk("ack",   80'({i_ack, d_ack}), 80'({e_ia, e_da}));
      chk("rdata", 80'({i_rdata, d_rdata}), 80'({e_ird, e_drd}));
      chk("mem",   80'({mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata}),
                   80'({e_mreq, e_mwe, e_mws, e_maddr, e_mwd}));
    end
  end

  task automatic drain();
    int k = 0;
    i_flush = 0;
    while ((i_req || d_req || m_busy) && k < 40) begin
      cyc();
      if (s_i_gnt) i_req = 0;
      if (s_d_gnt) d_req = 0;
      k++;
    end
    chk("drain_timeout", 80'(k < 40), 80'(1));
  endtask

  initial begin : stim
    int acks;
    int k;
    rst_n = 0; i_req = 0; i_addr = '0; i_flush = 0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_ack = 0; mem_rdata = '0;
    cyc(); cyc();
    chk("reset_outputs", 80'({i_gnt, d_gnt, i_ack, d_ack, mem_req, i_rdata, d_rdata}), 80'(0));
    rst_n = 1;
    cyc();

    // fetch only, latency 2
    fixed_en = 1; fixed_data = 32'hCAFE_0100; mem_lat = 2;
    i_req = 1; i_addr = 32'h100;
    cyc();
    chk("f_gnt_c0",  80'({s_i_gnt, s_mem_req, s_mem_we}), 80'(3'b110));
    chk("f_addr_c0", 80'(s_mem_addr), 80'(32'h100));
    i_req = 0;
    cyc();
    chk("f_ack_c1", 80'(s_i_ack), 80'(0));
    cyc();
    chk("f_ack_c2", 80'({s_i_ack, s_i_rdata}), 80'({1'b1, 32'hCAFE_0100}));
    fixed_en = 0;

    // starvation guard with both requests held
    mem_lat = 1; collect = 1; i_req = 1; d_req = 1; i_addr = 32'h180; d_addr = 32'h1000; d_we = 0;
    k = 0;
    while (dut_order.len() < 10 && k < 100) begin cyc(); k++; end
    collect = 0; i_req = 0; d_req = 0;
    n_assert++;
    if (dut_order != "DDDDIDDDDI") begin
      n_fail++; $display("FAIL grant_order_dut: got %s expected DDDDIDDDDI", dut_order);
    end
    n_assert++;
    if (model_order != "DDDDIDDDDI") begin
      n_fail++; $display("FAIL grant_order_model: got %s expected DDDDIDDDDI", model_order);
    end
    drain();

    // partial store
    fixed_en = 1; fixed_data = 32'hDEAD_BEEF; mem_lat = 2;
    d_req = 1; d_we = 1; d_wstrb = 4'h3; d_addr = 32'h2004; d_wdata = 32'h1234_5678;
    cyc();
    chk("st_mem", 80'({s_d_gnt, s_mem_we, s_mem_wstrb, s_mem_addr, s_mem_wdata}),
                  80'({1'b1, 1'b1, 4'h3, 32'h2004, 32'h1234_5678}));
    d_req = 0; d_we = 0; d_wstrb = 0;
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      cyc();
      if (s_d_ack) begin
        acks++;
        chk("st_rdata", 80'(s_d_rdata), 80'(0));
      end
    end
    chk("st_ack_count", 80'(acks), 80'(1));
    fixed_en = 0;

    // flush of an in-flight fetch, latency 3
    mem_lat = 3; i_req = 1; i_addr = 32'h200;
    acks = 0;
    cyc();
    chk("fl_gnt", 80'(s_i_gnt), 80'(1));
    i_req = 0; i_flush = 1;
    cyc(); acks += int'(s_i_ack);
    i_flush = 0;
    cyc(); acks += int'(s_i_ack);
    cyc(); acks += int'(s_i_ack);
    chk("fl_no_ack", 80'(acks), 80'(0));
    mem_lat = 1; d_req = 1; d_addr = 32'h3000;
    cyc();
    chk("fl_next_dgnt", 80'(s_d_gnt), 80'(1));
    d_req = 0;
    drain();

    // reset while a load is in flight, stale ack after release
    mem_lat = 4; d_req = 1; d_we = 0; d_addr = 32'h400;
    cyc();
    chk("rs_gnt", 80'(s_d_gnt), 80'(1));
    d_req = 0;
    cyc();
    rst_n = 0; i_req = 1; d_req = 1; i_addr = 32'h500;
    #1;
    chk("rs_async_zero", 80'({i_gnt, d_gnt, i_ack, d_ack, mem_req, mem_addr}), 80'(0));
    cyc();
    chk("rs_cycle_zero", 80'({s_i_gnt, s_d_gnt, s_i_ack, s_d_ack, s_mem_req}), 80'(0));
    rst_n = 1; i_req = 0; d_req = 0;
    acks = 0;
    cyc(); acks += int'(s_d_ack);
    cyc(); acks += int'(s_d_ack);
    chk("rs_no_ack", 80'(acks), 80'(0));
    mem_lat = 1; d_req = 1; d_addr = 32'h404;
    cyc();
    chk("rs_idle_gnt", 80'(s_d_gnt), 80'(1));
    d_req = 0;
    drain();

    // new requests landing on the ack cycle of a fetch
    mem_lat = 2; i_req = 1; i_addr = 32'h300;
    cyc();
    chk("ov_igntc0", 80'(s_i_gnt), 80'(1));
    i_req = 0;
    cyc();
    i_req = 1; i_addr = 32'h304; d_req = 1; d_addr = 32'h600;
    mem_lat = 1;
    cyc();
    chk("ov_ack_nognt", 80'({s_i_ack, s_i_gnt, s_d_gnt}), 80'(3'b100));
    cyc();
    chk("ov_dgnt_next", 80'({s_d_gnt, s_i_gnt}), 80'(2'b10));
    d_req = 0;
    drain();

    // random traffic
    mem_lat = 0;
    for (int c = 0; c < 2000; c++) begin
      cyc();
      if (s_i_gnt) i_req = 0;
      if (s_d_gnt) d_req = 0;
      if (!i_req && $urandom_range(0, 99) < 40) begin
        i_req = 1; i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req && $urandom_range(0, 99) < 40) begin
        d_req = 1; d_we = 1'($urandom); d_addr = $urandom;
        d_wdata = $urandom; d_wstrb = 4'($urandom);
      end
      i_flush = ($urandom_range(0, 99) < 10);
      rst_n = ($urandom_range(0, 999) >= 5);
    end
    rst_n = 1;
    drain();
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
